// File: rtl/output_act_ctrl.sv
// Packs narrow activation bytes LSB-first into wide words and buffers them in a
// FIFO with registered read data, a sticky overflow flag and an edge-triggered clear.
module output_act_ctrl #(
   parameter int INPUT_WIDTH  = 8,
   parameter int OUTPUT_WIDTH = 32,
   parameter int FIFO_DEPTH   = 64
) (
   input  logic                          CLK,
   input  logic                          RESETN,
   input  logic                          CLEAR_FIFO,
   input  logic                          FLUSH,
   input  logic [INPUT_WIDTH-1:0]        DATA_IN,
   input  logic                          DATA_VALID,
   input  logic                          FIFO_RD_CMD,
   output logic [OUTPUT_WIDTH-1:0]       FIFO_RD_DATA,
   output logic                          FIFO_EMPTY,
   output logic                          FIFO_FULL,
   output logic [$clog2(FIFO_DEPTH):0]   WORD_COUNT,
   output logic                          OVERFLOW
);
   localparam int LANES = OUTPUT_WIDTH / INPUT_WIDTH;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = AW + 1;
   localparam int LW    = $clog2(LANES);

   typedef enum logic {
      EMPTY_WORD = 1'b0,
      PARTIAL    = 1'b1
   } state_t;

   state_t                  state_reg, state_next;
   logic [LW-1:0]           lane_reg, lane_next;
   logic [OUTPUT_WIDTH-1:0] hold_reg, hold_next;
   logic [AW-1:0]           wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]           rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0]           count_reg, count_next;
   logic                    overflow_reg, overflow_next;
   logic                    clear_prev_reg;
   logic [OUTPUT_WIDTH-1:0] rd_data_reg;
   logic [OUTPUT_WIDTH-1:0] mem [FIFO_DEPTH];

   logic                    clear_edge;
   logic                    last_byte;
   logic                    emit;
   logic                    rd_accept;
   logic                    wr_accept;
   logic [OUTPUT_WIDTH-1:0] packed_word;

   // Holding register with the current byte merged into its lane; this is
   // exactly what gets written when the word completes or is flushed.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign packed_word[INPUT_WIDTH*gi +: INPUT_WIDTH] =
            (DATA_VALID && (lane_reg == LW'(gi))) ? DATA_IN
                                                  : hold_reg[INPUT_WIDTH*gi +: INPUT_WIDTH];
      end
   endgenerate

   always_comb begin
      clear_edge    = CLEAR_FIFO && !clear_prev_reg;
      last_byte     = DATA_VALID && (lane_reg == LW'(LANES-1));
      emit          = last_byte || (FLUSH && ((lane_reg != '0) || DATA_VALID));
      rd_accept     = FIFO_RD_CMD && (count_reg != '0);
      wr_accept     = emit && ((count_reg < CW'(FIFO_DEPTH)) || rd_accept);
      state_next    = state_reg;
      lane_next     = lane_reg;
      hold_next     = hold_reg;
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      count_next    = count_reg;
      overflow_next = overflow_reg;

      if (clear_edge) begin
         // Clear wins over every other request in the same cycle.
         state_next    = EMPTY_WORD;
         lane_next     = '0;
         hold_next     = '0;
         wr_ptr_next   = '0;
         rd_ptr_next   = '0;
         count_next    = '0;
         overflow_next = 1'b0;
         rd_accept     = 1'b0;
         wr_accept     = 1'b0;
      end else begin
         case (state_reg)
            EMPTY_WORD: if (DATA_VALID && !emit) state_next = PARTIAL;
            PARTIAL:    if (emit) state_next = EMPTY_WORD;
            default:    state_next = EMPTY_WORD;
         endcase

         if (emit) begin
            lane_next = '0;
            hold_next = '0;
         end else if (DATA_VALID) begin
            lane_next = lane_reg + 1'b1;
            hold_next = packed_word;
         end

         if (emit && !wr_accept) overflow_next = 1'b1;
         if (wr_accept) wr_ptr_next = wr_ptr_reg + 1'b1;
         if (rd_accept) rd_ptr_next = rd_ptr_reg + 1'b1;
         count_next = count_reg + CW'(wr_accept) - CW'(rd_accept);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state_reg      <= EMPTY_WORD;
         lane_reg       <= '0;
         hold_reg       <= '0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         overflow_reg   <= 1'b0;
         clear_prev_reg <= 1'b0;
         rd_data_reg    <= '0;
      end else begin
         state_reg      <= state_next;
         lane_reg       <= lane_next;
         hold_reg       <= hold_next;
         wr_ptr_reg     <= wr_ptr_next;
         rd_ptr_reg     <= rd_ptr_next;
         count_reg      <= count_next;
         overflow_reg   <= overflow_next;
         clear_prev_reg <= CLEAR_FIFO;
         // Read-before-write: a full FIFO reading and writing the same slot returns the old head.
         if (rd_accept) rd_data_reg <= mem[rd_ptr_reg];
      end
   end

   always_ff @(posedge CLK) begin
      if (RESETN && wr_accept) mem[wr_ptr_reg] <= packed_word;
   end

   assign FIFO_RD_DATA = rd_data_reg;
   assign FIFO_EMPTY   = (count_reg == '0);
   assign FIFO_FULL    = (count_reg == CW'(FIFO_DEPTH));
   assign WORD_COUNT   = count_reg;
   assign OVERFLOW     = overflow_reg;

endmodule

// File: tb/tb_output_act_ctrl.sv
// Scoreboard bench for output_act_ctrl: a behavioural packer/FIFO model queues
// expected words as bytes are driven; reads pop and compare them.
module tb_output_act_ctrl;
   localparam int IW    = 8;
   localparam int OW    = 32;
   localparam int DEPTH = 64;
   localparam int LANES = OW / IW;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          CLK = 1'b0;
   logic          RESETN = 1'b0;
   logic          CLEAR_FIFO = 1'b0;
   logic          FLUSH = 1'b0;
   logic [IW-1:0] DATA_IN = '0;
   logic          DATA_VALID = 1'b0;
   logic          FIFO_RD_CMD = 1'b0;
   logic [OW-1:0] FIFO_RD_DATA;
   logic          FIFO_EMPTY;
   logic          FIFO_FULL;
   logic [CW-1:0] WORD_COUNT;
   logic          OVERFLOW;

   int            tests_run = 0;
   int            tests_failed = 0;
   logic [OW-1:0] exp_q[$];
   int            m_lane = 0;
   logic [OW-1:0] m_word = '0;
   logic [OW-1:0] m_rd = '0;
   logic          m_ovf = 1'b0;
   logic          m_prev_clr = 1'b0;

   always #5 CLK = ~CLK;

   output_act_ctrl #(
      .INPUT_WIDTH (IW),
      .OUTPUT_WIDTH(OW),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .CLK         (CLK),
      .RESETN      (RESETN),
      .CLEAR_FIFO  (CLEAR_FIFO),
      .FLUSH       (FLUSH),
      .DATA_IN     (DATA_IN),
      .DATA_VALID  (DATA_VALID),
      .FIFO_RD_CMD (FIFO_RD_CMD),
      .FIFO_RD_DATA(FIFO_RD_DATA),
      .FIFO_EMPTY  (FIFO_EMPTY),
      .FIFO_FULL   (FIFO_FULL),
      .WORD_COUNT  (WORD_COUNT),
      .OVERFLOW    (OVERFLOW)
   );

   task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_status(input string tag);
      check({tag, " word_count"}, OW'(WORD_COUNT), OW'(exp_q.size()));
      check({tag, " empty"}, OW'(FIFO_EMPTY), OW'(exp_q.size() == 0));
      check({tag, " full"}, OW'(FIFO_FULL), OW'(exp_q.size() == DEPTH));
      check({tag, " overflow"}, OW'(OVERFLOW), OW'(m_ovf));
   endtask

   // One clock of stimulus; the model is advanced first, outputs checked #1 after the edge.
   task automatic step(input logic v, input logic [IW-1:0] d, input logic fl,
                       input logic rd, input logic clr, input string tag);
      logic [OW-1:0] w;
      logic          done;
      logic          rd_ok;
      rd_ok = 1'b0;
      if (clr && !m_prev_clr) begin
         exp_q.delete();
         m_lane = 0;
         m_word = '0;
         m_ovf  = 1'b0;
      end else begin
         if (rd && exp_q.size() != 0) begin
            rd_ok = 1'b1;
            m_rd  = exp_q.pop_front();
         end
         w = m_word;
         if (v) w[m_lane*IW +: IW] = d;
         done = (v && m_lane == LANES-1) || (fl && (m_lane != 0 || v));
         if (done) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(w);
            else m_ovf = 1'b1;
            m_lane = 0;
            m_word = '0;
         end else if (v) begin
            m_lane++;
            m_word = w;
         end
      end
      m_prev_clr = clr;

      DATA_VALID  = v;
      DATA_IN     = d;
      FLUSH       = fl;
      FIFO_RD_CMD = rd;
      CLEAR_FIFO  = clr;
      @(posedge CLK);
      #1;
      DATA_VALID  = 1'b0;
      FLUSH       = 1'b0;
      FIFO_RD_CMD = 1'b0;
      check({tag, rd_ok ? " rd_data" : " rd_hold"}, FIFO_RD_DATA, m_rd);
      check_status(tag);
      $display("[TB] %s v=%0d d=%02h fl=%0d rd=%0d clr=%0d -> cnt=%0d rd_data=%08h ovf=%0d",
               tag, v, d, fl, rd, clr, WORD_COUNT, FIFO_RD_DATA, OVERFLOW);
   endtask

   task automatic do_reset(input string tag);
      RESETN      = 1'b0;
      CLEAR_FIFO  = 1'b0;
      DATA_VALID  = 1'b0;
      FLUSH       = 1'b0;
      FIFO_RD_CMD = 1'b0;
      @(posedge CLK);
      #1;
      RESETN = 1'b1;
      exp_q.delete();
      m_lane     = 0;
      m_word     = '0;
      m_rd       = '0;
      m_ovf      = 1'b0;
      m_prev_clr = 1'b0;
      check({tag, " rd_data"}, FIFO_RD_DATA, '0);
      check_status(tag);
      $display("[TB] %s reset -> cnt=%0d empty=%0d full=%0d", tag, WORD_COUNT, FIFO_EMPTY, FIFO_FULL);
   endtask

   task automatic put_word(input logic [OW-1:0] w, input logic rd_last, input string tag);
      for (int k = 0; k < LANES; k++)
         step(1'b1, w[k*IW +: IW], 1'b0, rd_last && (k == LANES-1), 1'b0, tag);
   endtask

   initial begin
      logic clr_lvl;

      do_reset("reset");

      // Basic packing and read-back.
      put_word(32'h44332211, 1'b0, "pack");
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "pack_read");

      // Flush of a partial word, flush at lane 0, flush with the final byte.
      step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, "flush_partial");
      step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, "flush_partial");
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "flush_partial");
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "flush_lane0");
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "flush_read");
      step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, "flush_last");
      step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, "flush_last");
      step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, "flush_last");
      step(1'b1, 8'h04, 1'b1, 1'b0, 1'b0, "flush_last");
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "flush_read");

      // Read while empty holds data.
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "empty_read");

      // Fill, write while full with and without a same-cycle read, then drain.
      for (int i = 0; i < DEPTH; i++) put_word($urandom, 1'b0, "fill");
      put_word($urandom, 1'b1, "full_wr_rd");
      put_word($urandom, 1'b0, "full_drop");
      for (int i = 0; i < DEPTH + 2 && exp_q.size() != 0; i++)
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "drain");
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "empty_read");

      // Clear with 3 words stored, lane 2 and overflow set; held high 10 cycles.
      for (int i = 0; i < 3; i++) put_word($urandom, 1'b0, "pre_clear");
      step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, "pre_clear");
      step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, "pre_clear");
      step(1'b1, 8'h77, 1'b1, 1'b1, 1'b1, "clear_edge");
      step(1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, "clear_held");
      step(1'b1, 8'hC2, 1'b0, 1'b0, 1'b1, "clear_held");
      step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, "clear_held");
      step(1'b1, 8'hC4, 1'b0, 1'b0, 1'b1, "clear_held");
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, "clear_held");
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clear_held");
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "clear_low");

      // Mixed random traffic including occasional clears.
      clr_lvl = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) clr_lvl = ~clr_lvl;
         step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 9) == 0,
              $urandom_range(0, 2) == 0, clr_lvl, "random");
      end
      for (int i = 0; i < DEPTH + 2 && exp_q.size() != 0; i++)
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "random_drain");

      // Reset mid-word, then a clean word.
      do_reset("reset_pre");
      step(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0, "mid_word");
      step(1'b1, 8'hE2, 1'b0, 1'b0, 1'b0, "mid_word");
      do_reset("reset_mid");
      put_word(32'hD4C3B2A1, 1'b0, "post_reset");
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "post_reset_read");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/output_act_ctrl.md
OUTPUT_ACT_CTRL -- requirements
Module: output_act_ctrl

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 8, meaning the width of one activation byte from the compute array.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 32, meaning the packed FIFO word width; OUTPUT_WIDTH/INPUT_WIDTH (LANES, default 4) is an integer of at least 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 64, meaning the number of words; it is a power of 2.
REQ-004 SHALL have port CLK, input, 1 bit: clock, all logic on the rising edge.
REQ-005 SHALL have port RESETN, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port CLEAR_FIFO, input, 1 bit: level from the mem_ctrl register; only its rising edge acts.
REQ-007 SHALL have port FLUSH, input, 1 bit: one-cycle pulse that emits a partial word.
REQ-008 SHALL have port DATA_IN, input, INPUT_WIDTH bits: activation byte.
REQ-009 SHALL have port DATA_VALID, input, 1 bit: DATA_IN is valid this cycle; there is no backpressure.
REQ-010 SHALL have port FIFO_RD_CMD, input, 1 bit: external read request.
REQ-011 SHALL have port FIFO_RD_DATA, output, OUTPUT_WIDTH bits: registered read data.
REQ-012 SHALL have port FIFO_EMPTY, output, 1 bit: word count == 0.
REQ-013 SHALL have port FIFO_FULL, output, 1 bit: word count == FIFO_DEPTH.
REQ-014 SHALL have port WORD_COUNT, output, $clog2(FIFO_DEPTH)+1 bits: words stored.
REQ-015 SHALL have port OVERFLOW, output, 1 bit: sticky flag, set when a word is dropped.

Function
REQ-016 SHALL pack bytes LSB-first: the k-th valid byte of a word goes to bits [INPUT_WIDTH*(k+1)-1 : INPUT_WIDTH*k], tracked by lane counter 0..LANES-1.
REQ-017 SHALL implement FSM states:
- EMPTY_WORD: lane = 0.
- PARTIAL: 0 < lane < LANES.
- EMPTY_WORD -> PARTIAL on DATA_VALID.
- PARTIAL -> EMPTY_WORD when a word is completed or flushed.
REQ-018 SHALL write the completed word into the FIFO on the same edge that samples the LANES-th valid byte; the lane returns to 0 and the holding register clears to 0.
REQ-019 SHALL apply the new count after that edge, so FIFO_EMPTY/FIFO_FULL/WORD_COUNT change one cycle after the final byte is presented.
REQ-020 SHALL, on FLUSH with lane > 0, write the partial word with the unfilled upper lanes zero-padded, then return to lane 0.
REQ-021 SHALL treat FLUSH with lane == 0 and DATA_VALID low as a no-op.
REQ-022 SHALL, on FLUSH with DATA_VALID high in the same cycle, include that byte first; if it completes the word, exactly one word is written (no extra empty word).
REQ-023 SHALL accept a write only if the count is below FIFO_DEPTH, or if FIFO_RD_CMD is accepted in the same cycle (count unchanged).
REQ-024 SHALL otherwise drop the word, set OVERFLOW, and still reset the lane to 0.
REQ-025 SHALL accept FIFO_RD_CMD only when FIFO_EMPTY = 0; on acceptance FIFO_RD_DATA loads the head word on that edge (visible the next cycle), the read pointer advances and the count decrements.
REQ-026 SHALL ignore FIFO_RD_CMD while empty, holding FIFO_RD_DATA, with no underflow and no pointer move.
REQ-027 SHALL, on a simultaneous accepted read and write, keep the count unchanged and move both pointers.
REQ-028 SHALL let the pointers wrap modulo FIFO_DEPTH.
REQ-029 SHALL detect a CLEAR_FIFO rising edge as CLEAR_FIFO = 1 with its registered previous value = 0.
REQ-030 SHALL, on that edge, zero the pointers, count, lane, holding register and OVERFLOW, and discard any DATA_VALID/FLUSH/FIFO_RD_CMD in that cycle.
REQ-031 SHALL leave FIFO_RD_DATA unchanged on a clear.
REQ-032 SHALL give a held-high CLEAR_FIFO no further effect.

Reset
REQ-033 SHALL, while RESETN = 0 at a clock edge, set pointers, count, lane, holding register, FIFO_RD_DATA, OVERFLOW and the CLEAR_FIFO edge register to 0.
REQ-034 SHALL therefore drive FIFO_EMPTY = 1, FIFO_FULL = 0 and WORD_COUNT = 0 after reset.
REQ-035 SHALL, on a reset mid-word or mid-read, discard all partial and stored data; storage contents need not be reset.

Verification
REQ-036 SHALL verify packing: bytes 0x11,0x22,0x33,0x44 valid on 4 consecutive cycles -> next cycle FIFO_EMPTY = 0, WORD_COUNT = 1; FIFO_RD_CMD for 1 cycle -> next cycle FIFO_RD_DATA = 0x44332211, FIFO_EMPTY = 1.
REQ-037 SHALL verify flush cases:
- 0xAA,0xBB then FLUSH -> word 0x0000BBAA stored.
- FLUSH at lane 0 -> WORD_COUNT unchanged.
- FLUSH with the 4th byte -> exactly one word stored.
REQ-038 SHALL verify full/overflow: 64 words written -> FIFO_FULL = 1.
- A 65th word -> dropped, OVERFLOW = 1, WORD_COUNT = 64.
- A 65th word completing with a same-cycle read -> accepted, OVERFLOW stays 0.
REQ-039 SHALL verify empty read: FIFO_RD_CMD while empty -> FIFO_RD_DATA holds its prior value, WORD_COUNT stays 0, no error.
REQ-040 SHALL verify clear: 3 words stored, lane = 2, OVERFLOW = 1, CLEAR_FIFO rises and is held high 10 cycles -> after the edge WORD_COUNT = 0, lane = 0, OVERFLOW = 0; packing resumes normally while CLEAR_FIFO is still high.
REQ-041 SHALL verify reset mid-word: 2 bytes fed then RESETN low 1 cycle -> all outputs at reset values; the next 4 bytes form a clean word.
